// File: rtl/bus_xcvr_arbiter_pkg.sv
// Shared types and helpers for the bus transceiver arbiter: FSM encoding,
// the upper bound on requester count, and a modulo pointer increment.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_TURN  = 2'd2
   } arb_state_t;

   localparam int ARB_MAX_REQ = 8;

   // Increment with wrap at n, so non-power-of-two requester counts stay in range.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/bus_xcvr_arbiter_if.sv
// Requester/transceiver-bank bundle. master = arbiter side (drives grants),
// slave = requester/transceiver side (drives requests and directions).
interface bus_xcvr_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] wr;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] nOE;
   logic [N_REQ-1:0] dir;
   logic             busy;
   logic [OW-1:0]    owner;

   modport master (
      input  req, wr,
      output gnt, nOE, dir, busy, owner
   );

   modport slave (
      output req, wr,
      input  gnt, nOE, dir, busy, owner
   );

endinterface

// File: rtl/bus_xcvr_arbiter_chk.sv
// Safety invariants of the transceiver bank: at most one enabled driver,
// enables mirror grants, direction only asserted on an enabled transceiver.
module bus_xcvr_arbiter_chk
   import bus_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int LOG   = 0
) (
   input logic             clk_i,
   input logic             rst_ni,
   input logic [N_REQ-1:0] gnt_i,
   input logic [N_REQ-1:0] n_oe_i,
   input logic [N_REQ-1:0] dir_i,
   input logic             busy_i
);

   a_param: assert property (@(posedge clk_i) (N_REQ >= 2) && (N_REQ <= ARB_MAX_REQ));

   a_one_driver: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(~n_oe_i));

   a_oe_is_not_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) n_oe_i == ~gnt_i);

   a_dir_only_enabled: assert property (@(posedge clk_i) disable iff (!rst_ni) (dir_i & n_oe_i) == '0);

   a_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) busy_i == (|gnt_i));

   if (LOG != 0) begin : g_log
      c_grant: cover property (@(posedge clk_i) disable iff (!rst_ni) $rose(busy_i));
      c_release: cover property (@(posedge clk_i) disable iff (!rst_ni) $fell(busy_i));
   end

endmodule

// File: rtl/bus_xcvr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N, reported as one-hot, index and valid.
module rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] pick_o,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   // Scan descending so the candidate nearest the pointer (k = 0) is written last and wins.
   always_comb begin
      int            c;
      logic          hit;
      logic [N-1:0]  one_hot;
      pick_o  = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      hit     = 1'b0;
      one_hot = '0;
      for (int k = N - 1; k >= 0; k--) begin
         c       = int'(ptr_i) + k;
         c       = (c >= N) ? c - N : c;
         one_hot = {{(N-1){1'b0}}, 1'b1} << c;
         hit     = |(req_i & one_hot);
         pick_o  = hit ? one_hot : pick_o;
         idx_o   = hit ? W'(c) : idx_o;
         valid_o = valid_o | hit;
      end
   end

endmodule

// File: rtl/bus_xcvr_arbiter.sv
// Round-robin owner sequencer for a bank of 74245-style transceivers sharing one bus,
// with bounded hold time and all-off turnaround between owners.
module bus_xcvr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DEAD_CYCLES = 1,
   parameter int MAX_HOLD    = 16,
   parameter int LOG         = 0
) (
   input logic                 clk,
   input logic                 nRESET,
   bus_xcvr_arbiter_if.master  bus
);

   localparam int OW = $clog2(N_REQ);
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   localparam logic [1:0]    ST_IDLE   = ARB_IDLE;
   localparam logic [1:0]    ST_GRANT  = ARB_GRANT;
   localparam logic [1:0]    ST_TURN   = ARB_TURN;
   localparam logic [HW-1:0] HOLD_SAT  = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : '1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [2:0]    TURN_LAST = 3'(DEAD_CYCLES - 1);

   logic [1:0]       state_q,  state_d;
   logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]    owner_q,  owner_d;
   logic [HW-1:0]    hold_q,   hold_d;
   logic [2:0]       turn_q,   turn_d;
   logic [N_REQ-1:0] gnt_q,    gnt_d;
   logic [N_REQ-1:0] dir_q,    dir_d;

   logic [N_REQ-1:0] pick_s;
   logic [OW-1:0]    pick_idx_s;
   logic             pick_valid_s;
   logic             owner_req_s;
   logic             others_req_s;
   logic             preempt_s;
   logic             release_s;

   rr_pick #(
      .N (N_REQ),
      .W (OW)
   ) u_pick (
      .req_i   (bus.req),
      .ptr_i   (rr_ptr_q),
      .pick_o  (pick_s),
      .idx_o   (pick_idx_s),
      .valid_o (pick_valid_s)
   );

   // gnt_q is one-hot in GRANT, so masking with it isolates the owner's request.
   assign owner_req_s  = |(bus.req & gnt_q);
   assign others_req_s = |(bus.req & ~gnt_q);
   assign preempt_s    = (MAX_HOLD > 0) && (hold_q >= HOLD_LAST) && others_req_s;
   assign release_s    = !owner_req_s || preempt_s;

   // Next-state and next-output logic of the IDLE / GRANT / TURN sequencer.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      hold_d   = hold_q;
      turn_d   = turn_q;
      gnt_d    = gnt_q;
      dir_d    = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_d = ST_GRANT;
               gnt_d   = pick_s;
               dir_d   = pick_s & bus.wr;
               owner_d = pick_idx_s;
               hold_d  = '0;
            end else begin
               gnt_d = '0;
               dir_d = '0;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               gnt_d    = '0;
               dir_d    = '0;
               rr_ptr_d = OW'(wrap_inc(int'(owner_q), N_REQ));
               turn_d   = 3'd0;
               state_d  = (DEAD_CYCLES > 0) ? ST_TURN : ST_IDLE;
            end else begin
               hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);
            end
         end
         ST_TURN: begin
            if (turn_q == TURN_LAST) begin
               state_d = ST_IDLE;
            end else begin
               turn_d = turn_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            dir_d   = '0;
         end
      endcase
   end

   // State and output registers; reset drops every enable without waiting for a clock.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         hold_q   <= '0;
         turn_q   <= 3'd0;
         gnt_q    <= '0;
         dir_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         hold_q   <= hold_d;
         turn_q   <= turn_d;
         gnt_q    <= gnt_d;
         dir_q    <= dir_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.nOE   = ~gnt_q;
   assign bus.dir   = dir_q;
   assign bus.busy  = |gnt_q;
   assign bus.owner = owner_q;

   bus_xcvr_arbiter_chk #(
      .N_REQ (N_REQ),
      .LOG   (LOG)
   ) u_chk (
      .clk_i  (clk),
      .rst_ni (nRESET),
      .gnt_i  (gnt_q),
      .n_oe_i (bus.nOE),
      .dir_i  (dir_q),
      .busy_i (bus.busy)
   );

endmodule

// File: tb/tb_bus_xcvr_arbiter.sv
// Bench for bus_xcvr_arbiter: directed scenarios on a 4-requester instance and a
// random soak on a 3-requester, zero-dead-cycle instance, both tracked by a model.
module tb_bus_xcvr_arbiter;

   typedef struct packed {
      int         owner;   // -1 when nobody holds the bus
      int         last;
      int         ptr;
      int         len;     // clocks the current grant has been visible
      int         gap;     // all-off turnaround clocks still to go
      logic [7:0] dirv;
   } mdl_t;

   localparam mdl_t MDL_RST = '{owner: -1, last: 0, ptr: 0, len: 0, gap: 0, dirv: 8'h00};

   logic clk = 1'b0;
   logic nreset;
   logic nreset2;
   int   n_tests = 0;
   int   n_fail  = 0;
   mdl_t m1, m2;

   always #5 clk = ~clk;

   bus_xcvr_arbiter_if #(.N_REQ(4)) if1 ();
   bus_xcvr_arbiter_if #(.N_REQ(3)) if2 ();

   bus_xcvr_arbiter #(.N_REQ(4), .DEAD_CYCLES(1), .MAX_HOLD(16), .LOG(0)) dut1 (
      .clk    (clk),
      .nRESET (nreset),
      .bus    (if1)
   );

   bus_xcvr_arbiter #(.N_REQ(3), .DEAD_CYCLES(0), .MAX_HOLD(4), .LOG(0)) dut2 (
      .clk    (clk),
      .nRESET (nreset2),
      .bus    (if2)
   );

   // One clock of the arbitration rules, stated in terms of owners and clock counts.
   function automatic mdl_t mdl_step(input mdl_t m, input int n, input int dead, input int maxh,
                                     input logic [7:0] rq, input logic [7:0] w);
      mdl_t r;
      logic others;
      logic found;
      int   c;
      r = m;
      found = 1'b0;
      if (r.owner >= 0) begin
         others = |(rq & ~(8'h01 << r.owner));
         if (!rq[r.owner] || (maxh > 0 && others && r.len >= maxh)) begin
            r.ptr   = (r.owner + 1) % n;
            r.owner = -1;
            r.gap   = dead;
            r.dirv  = 8'h00;
         end else begin
            r.len = r.len + 1;
         end
      end else if (r.gap > 0) begin
         r.gap = r.gap - 1;
      end else begin
         for (int k = 0; k < n; k++) begin
            c = (r.ptr + k) % n;
            if (!found && rq[c]) begin
               found   = 1'b1;
               r.owner = c;
               r.last  = c;
               r.len   = 1;
               r.dirv  = 8'h00;
               r.dirv[c] = w[c];
            end
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge nreset) begin
      if (!nreset) m1 <= MDL_RST;
      else         m1 <= mdl_step(m1, 4, 1, 16, {4'b0000, if1.req}, {4'b0000, if1.wr});
   end

   always @(posedge clk or negedge nreset2) begin
      if (!nreset2) m2 <= MDL_RST;
      else          m2 <= mdl_step(m2, 3, 0, 4, {5'b00000, if2.req}, {5'b00000, if2.wr});
   end

   task automatic cmp_dut(input string nm, input logic [7:0] g, input logic [7:0] oe,
                          input logic [7:0] d, input logic b, input logic [7:0] ow,
                          input mdl_t m, input int n);
      logic [7:0] mask;
      logic [7:0] eg;
      mask = (8'h01 << n) - 8'h01;
      eg   = (m.owner >= 0) ? (8'h01 << m.owner) : 8'h00;
      n_tests++;
      if (g !== eg || oe !== (~eg & mask) || d !== m.dirv || b !== (m.owner >= 0)
          || ow !== 8'(m.last)) begin
         n_fail++;
         $display("FAIL %s @%0t: gnt=%b nOE=%b dir=%b busy=%b owner=%0d, expected gnt=%b nOE=%b dir=%b busy=%b owner=%0d",
                  nm, $time, g, oe, d, b, ow, eg, ~eg & mask, m.dirv, m.owner >= 0, m.last);
      end
   endtask

   always @(negedge clk) begin
      cmp_dut("model_dut1", {4'b0000, if1.gnt}, {4'b0000, if1.nOE}, {4'b0000, if1.dir},
              if1.busy, {6'b000000, if1.owner}, m1, 4);
      cmp_dut("model_dut2", {5'b00000, if2.gnt}, {5'b00000, if2.nOE}, {5'b00000, if2.dir},
              if2.busy, {6'b000000, if2.owner}, m2, 3);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_pulse();
      if1.req = 4'b0000;
      nreset  = 1'b0;
      tick(1);
      nreset  = 1'b1;
   endtask

   // Waits (bounded) for dut1 to grant; off = all-off clocks seen on the way.
   task automatic wait_gnt(output int idx, output int off);
      off = 0;
      idx = -1;
      while (if1.gnt == 4'b0000 && off < 40) begin
         off++;
         @(negedge clk);
      end
      if (if1.gnt == 4'b0000) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_gnt @%0t: no grant after %0d clocks, expected a grant", $time, off);
      end else begin
         for (int i = 0; i < 4; i++) if (if1.gnt[i]) idx = i;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int off;
      int hold;
      int wt[3];
      int maxw[3];
      int rr_exp[5];
      rr_exp = '{0, 1, 2, 3, 0};
      nreset  = 1'b0;
      nreset2 = 1'b0;
      if2.req = 3'b000;
      if2.wr  = 3'b000;

      // Reset with arbitrary requests present
      if1.req = 4'($urandom);
      if1.wr  = 4'($urandom);
      tick(2);
      chk("rst_nOE",  {28'd0, if1.nOE}, 32'h0000_000F);
      chk("rst_gnt",  {28'd0, if1.gnt}, 32'h0000_0000);
      chk("rst_dir",  {28'd0, if1.dir}, 32'h0000_0000);
      chk("rst_busy", {31'd0, if1.busy}, 32'h0000_0000);
      if1.req = 4'b0000;
      nreset  = 1'b1;
      nreset2 = 1'b1;
      tick(2);
      chk("idle_nOE", {28'd0, if1.nOE}, 32'h0000_000F);

      // Single requester, one clock latency, then turnaround
      if1.req = 4'b0100;
      if1.wr  = 4'b0100;
      tick(1);
      chk("single_gnt",   {28'd0, if1.gnt}, 32'h0000_0004);
      chk("single_nOE",   {28'd0, if1.nOE}, 32'h0000_000B);
      chk("single_dir",   {28'd0, if1.dir}, 32'h0000_0004);
      chk("single_owner", {30'd0, if1.owner}, 32'd2);
      if1.req = 4'b0000;
      tick(1);
      chk("release_nOE", {28'd0, if1.nOE}, 32'h0000_000F);
      tick(1);
      chk("dead_nOE",  {28'd0, if1.nOE}, 32'h0000_000F);
      chk("dead_busy", {31'd0, if1.busy}, 32'h0000_0000);

      // Round robin among four persistent requesters
      reset_pulse();
      if1.req = 4'b1111;
      if1.wr  = 4'b0000;
      tick(1);
      for (int g = 0; g < 5; g++) begin
         wait_gnt(idx, off);
         chk("rr_order", idx, rr_exp[g]);
         if (g > 0) chk("rr_gap", off, 32'd2);
         if1.req = 4'b1111;
         tick(2);
         if1.req = 4'b1111 & ~(4'b0001 << idx);
         tick(1);
      end
      if1.req = 4'b0000;
      tick(3);

      // Preemption at the hold limit
      reset_pulse();
      if1.req = 4'b0001;
      tick(1);
      wait_gnt(idx, off);
      chk("pre_first", idx, 32'd0);
      hold = 1;
      for (int k = 0; k < 40; k++) begin
         tick(1);
         if (k == 4) if1.req = 4'b1001;
         if (if1.gnt != 4'b0001) break;
         hold++;
      end
      chk("pre_hold", hold, 32'd16);
      wait_gnt(idx, off);
      chk("pre_next", idx, 32'd3);
      chk("pre_gap",  off, 32'd2);
      if1.req = 4'b0001;
      tick(1);
      wait_gnt(idx, off);
      chk("pre_back",     idx, 32'd0);
      chk("pre_back_gap", off, 32'd2);
      if1.req = 4'b0000;
      tick(3);

      // Direction latched at grant
      reset_pulse();
      if1.req = 4'b0010;
      if1.wr  = 4'b0000;
      tick(1);
      wait_gnt(idx, off);
      chk("dir_owner", idx, 32'd1);
      chk("dir_grant", {28'd0, if1.dir}, 32'h0000_0000);
      if1.wr = 4'b0010;
      tick(2);
      chk("dir_latched", {28'd0, if1.dir}, 32'h0000_0000);
      if1.req = 4'b0000;
      tick(1);
      if1.req = 4'b0010;
      wait_gnt(idx, off);
      chk("dir_regrant_owner", idx, 32'd1);
      chk("dir_regrant", {28'd0, if1.dir}, 32'h0000_0002);

      // Asynchronous reset while granted
      #1;
      nreset = 1'b0;
      #1;
      chk("async_nOE", {28'd0, if1.nOE}, 32'h0000_000F);
      chk("async_gnt", {28'd0, if1.gnt}, 32'h0000_0000);
      @(negedge clk);
      if1.req = 4'b0000;
      nreset  = 1'b1;
      tick(2);
      chk("post_rst_nOE", {28'd0, if1.nOE}, 32'h0000_000F);
      if1.req = 4'b1010;
      tick(1);
      wait_gnt(idx, off);
      chk("post_rst_ptr", idx, 32'd1);
      if1.req = 4'b0000;
      tick(3);

      // Random soak on the 3-requester instance
      for (int i = 0; i < 3; i++) begin
         wt[i]   = 0;
         maxw[i] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         tick(1);
         for (int i = 0; i < 3; i++) begin
            if (if2.req[i] && !if2.gnt[i]) wt[i]++;
            else wt[i] = 0;
            if (wt[i] > maxw[i]) maxw[i] = wt[i];
            if (if2.gnt[i]) begin
               if ($urandom_range(5, 0) == 0) if2.req[i] = 1'b0;
            end else if (!if2.req[i]) begin
               if ($urandom_range(2, 0) == 0) if2.req[i] = 1'b1;
            end else if ($urandom_range(49, 0) == 0) begin
               if2.req[i] = 1'b0;
            end
         end
         if2.wr = 3'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (maxw[i] > 3 * 4 + 6) begin
            n_fail++;
            $display("FAIL soak_starve req%0d: waited %0d clocks, expected at most %0d", i, maxw[i], 3 * 4 + 6);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
